// File: rtl/counter_header_stripper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_header_stripper_pkg
// Purpose  : Shared constants and state encoding for the counter header path.
// Revision : 1.0 - initial release
// ============================================================================
package counter_header_stripper_pkg;

   localparam int c_HDR_BYTES = 4;
   localparam int c_SEQ_W     = 32;

   typedef enum logic [1:0] {
      ST_HEAD  = 2'd0,
      ST_BODY  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_header_stripper_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : counter_header_stripper_axis_out_reg
// Purpose  : Registered AXI-Stream output stage with load-permission logic.
// Revision : 1.0 - initial release
// ============================================================================
module counter_header_stripper_axis_out_reg #(
   parameter int DW = 512
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic [DW-1:0]   i_data,
   input  logic [DW/8-1:0] i_keep,
   input  logic            i_last,
   input  logic            i_ready,
   output logic            o_valid,
   output logic [DW-1:0]   o_data,
   output logic [DW/8-1:0] o_keep,
   output logic            o_last,
   output logic            o_free
);

   logic            r_valid;
   logic [DW-1:0]   r_data;
   logic [DW/8-1:0] r_keep;
   logic            r_last;
   logic            w_free;

   // Register may take a new beat when empty or when its beat leaves this cycle.
   assign w_free = !r_valid || i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_keep  <= '0;
         r_last  <= 1'b0;
      end else if (w_free) begin
         r_valid <= i_load;
         if (i_load) begin
            r_data <= i_data;
            r_keep <= i_keep;
            r_last <= i_last;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_keep  = r_keep;
   assign o_last  = r_last;
   assign o_free  = w_free;

endmodule
`default_nettype wire

// File: rtl/counter_header_stripper.sv
`default_nettype none
// ============================================================================
// Module   : counter_header_stripper
// Purpose  : Strips a 32-bit sequence header, re-aligns payload, checks order.
// Revision : 1.0 - initial release
// ============================================================================
module counter_header_stripper
   import counter_header_stripper_pkg::*;
#(
   parameter int DW        = 512,
   parameter int HDR_BYTES = c_HDR_BYTES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   AXIS_IN_TDATA,
   input  logic            AXIS_IN_TVALID,
   output logic            AXIS_IN_TREADY,
   input  logic [DW/8-1:0] AXIS_IN_TKEEP,
   input  logic            AXIS_IN_TLAST,
   output logic [DW-1:0]   AXIS_OUT_TDATA,
   output logic            AXIS_OUT_TVALID,
   input  logic            AXIS_OUT_TREADY,
   output logic [DW/8-1:0] AXIS_OUT_TKEEP,
   output logic            AXIS_OUT_TLAST,
   output logic            seq_err,
   output logic [31:0]     err_count,
   output logic [31:0]     pkt_count,
   output logic [31:0]     last_seq
);

   localparam int KW  = DW / 8;
   localparam int H   = 8 * HDR_BYTES;
   localparam int RW  = DW - H;
   localparam int RKW = KW - HDR_BYTES;

   state_t             r_state;
   logic [RW-1:0]      r_hold;
   logic [RKW-1:0]     r_hold_keep;
   logic [c_SEQ_W-1:0] r_expected;
   logic               r_seq_err;
   logic [31:0]        r_err_count;
   logic [31:0]        r_pkt_count;
   logic [31:0]        r_last_seq;

   logic               w_out_free;
   logic               w_accept;
   logic [RKW-1:0]     w_rest_keep;
   logic               w_rest_empty;
   logic [c_SEQ_W-1:0] w_seq;
   logic               w_load;
   logic [DW-1:0]      w_out_data;
   logic [KW-1:0]      w_out_keep;
   logic               w_out_last;

   assign AXIS_IN_TREADY = w_out_free && (r_state != ST_FLUSH) && !reset;
   assign w_accept       = AXIS_IN_TVALID && AXIS_IN_TREADY;
   assign w_rest_keep    = AXIS_IN_TKEEP[KW-1:HDR_BYTES];
   assign w_rest_empty   = (w_rest_keep == '0);
   assign w_seq          = AXIS_IN_TDATA[c_SEQ_W-1:0];

   // Output beat = carried tail of the previous beat plus the head of this one.
   always_comb begin
      w_load     = 1'b0;
      w_out_data = '0;
      w_out_keep = '0;
      w_out_last = 1'b0;
      case (r_state)
         ST_BODY: begin
            w_load     = w_accept;
            w_out_data = {AXIS_IN_TDATA[H-1:0], r_hold};
            w_out_keep = {AXIS_IN_TKEEP[HDR_BYTES-1:0], r_hold_keep};
            w_out_last = AXIS_IN_TLAST && w_rest_empty;
         end
         ST_FLUSH: begin
            w_load     = w_out_free;
            w_out_data = {{H{1'b0}}, r_hold};
            w_out_keep = {{HDR_BYTES{1'b0}}, r_hold_keep};
            w_out_last = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_HEAD;
         r_hold      <= '0;
         r_hold_keep <= '0;
         r_expected  <= '0;
         r_seq_err   <= 1'b0;
         r_err_count <= '0;
         r_pkt_count <= '0;
         r_last_seq  <= '0;
      end else begin
         r_seq_err <= 1'b0;
         case (r_state)
            ST_HEAD: begin
               if (w_accept) begin
                  r_last_seq  <= w_seq;
                  r_pkt_count <= r_pkt_count + 32'd1;
                  if (w_seq != r_expected) begin
                     r_seq_err   <= 1'b1;
                     r_err_count <= r_err_count + 32'd1;
                  end
                  // Always resynchronise to the received value.
                  r_expected  <= w_seq + 32'd1;
                  r_hold      <= AXIS_IN_TDATA[DW-1:H];
                  r_hold_keep <= w_rest_keep;
                  if (!AXIS_IN_TLAST)
                     r_state <= ST_BODY;
                  else if (!w_rest_empty)
                     r_state <= ST_FLUSH;
                  else
                     r_state <= ST_HEAD;
               end
            end
            ST_BODY: begin
               if (w_accept) begin
                  r_hold      <= AXIS_IN_TDATA[DW-1:H];
                  r_hold_keep <= w_rest_keep;
                  if (AXIS_IN_TLAST)
                     r_state <= w_rest_empty ? ST_HEAD : ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (w_out_free)
                  r_state <= ST_HEAD;
            end
            default: r_state <= ST_HEAD;
         endcase
      end
   end

   counter_header_stripper_axis_out_reg #(
      .DW (DW)
   ) u_out_reg (
      .clk     (clk),
      .rst     (reset),
      .i_load  (w_load),
      .i_data  (w_out_data),
      .i_keep  (w_out_keep),
      .i_last  (w_out_last),
      .i_ready (AXIS_OUT_TREADY),
      .o_valid (AXIS_OUT_TVALID),
      .o_data  (AXIS_OUT_TDATA),
      .o_keep  (AXIS_OUT_TKEEP),
      .o_last  (AXIS_OUT_TLAST),
      .o_free  (w_out_free)
   );

   assign seq_err   = r_seq_err;
   assign err_count = r_err_count;
   assign pkt_count = r_pkt_count;
   assign last_seq  = r_last_seq;

endmodule
`default_nettype wire

// File: tb/tb_counter_header_stripper.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_header_stripper
// Purpose  : Directed and randomised self-checking bench for the stripper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_header_stripper;

   localparam int DW = 512;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic          l;
      logic [KW-1:0] k;
      logic [DW-1:0] d;
   } beat_t;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic [DW-1:0] in_tdata  = '0;
   logic          in_tvalid = 1'b0;
   logic          in_tready;
   logic [KW-1:0] in_tkeep  = '0;
   logic          in_tlast  = 1'b0;
   logic [DW-1:0] out_tdata;
   logic          out_tvalid;
   logic          out_tready = 1'b1;
   logic [KW-1:0] out_tkeep;
   logic          out_tlast;
   logic          seq_err;
   logic [31:0]   err_count;
   logic [31:0]   pkt_count;
   logic [31:0]   last_seq;

   always #5 clk = ~clk;

   counter_header_stripper #(.DW(DW), .HDR_BYTES(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .AXIS_IN_TDATA   (in_tdata),
      .AXIS_IN_TVALID  (in_tvalid),
      .AXIS_IN_TREADY  (in_tready),
      .AXIS_IN_TKEEP   (in_tkeep),
      .AXIS_IN_TLAST   (in_tlast),
      .AXIS_OUT_TDATA  (out_tdata),
      .AXIS_OUT_TVALID (out_tvalid),
      .AXIS_OUT_TREADY (out_tready),
      .AXIS_OUT_TKEEP  (out_tkeep),
      .AXIS_OUT_TLAST  (out_tlast),
      .seq_err         (seq_err),
      .err_count       (err_count),
      .pkt_count       (pkt_count),
      .last_seq        (last_seq)
   );

   int    n_vec = 0;
   int    n_err = 0;
   logic  rand_rdy = 1'b0;

   // Output observer: captured beats, error pulses, ready-low cycles, stall violations.
   beat_t cap_q[$];
   int    n_pulse   = 0;
   int    n_rdy_low = 0;
   int    n_stab    = 0;
   logic  prev_stall = 1'b0;
   beat_t prev_beat  = '0;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (out_tvalid !== 1'b1 || {out_tlast, out_tkeep, out_tdata} !== prev_beat))
            n_stab <= n_stab + 1;
         prev_stall <= out_tvalid && !out_tready;
         prev_beat  <= {out_tlast, out_tkeep, out_tdata};
         if (out_tvalid && out_tready)
            cap_q.push_back({out_tlast, out_tkeep, out_tdata});
         if (seq_err)
            n_pulse <= n_pulse + 1;
         if (!in_tready)
            n_rdy_low <= n_rdy_low + 1;
      end
   end

   task check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task check_beat(input string tag, input int idx, input beat_t e);
      if (idx >= cap_q.size()) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: beat %0d observed missing required present", tag, idx);
      end else begin
         check({tag, "_data"}, cap_q[idx].d, e.d);
         check({tag, "_keep"}, DW'(cap_q[idx].k), DW'(e.k));
         check({tag, "_last"}, DW'(cap_q[idx].l), DW'(e.l));
      end
   endtask

   task tick();
      @(posedge clk);
      #1;
      if (rand_rdy)
         out_tready = 1'($urandom_range(0, 1));
      #1;
   endtask

   task idle(input int n);
      repeat (n) tick();
   endtask

   task send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      int cyc;
      cyc = 0;
      in_tdata  = d;
      in_tkeep  = k;
      in_tlast  = l;
      in_tvalid = 1'b1;
      while (in_tready !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
      if (cyc >= 100) begin
         n_vec++;
         n_err++;
         $error("FAIL send_timeout: observed ready low for %0d cycles required accept", cyc);
      end else begin
         tick();
      end
      in_tvalid = 1'b0;
      in_tdata  = '0;
      in_tkeep  = '0;
      in_tlast  = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++)
         v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [DW-1:0] mask_data(input logic [DW-1:0] d, input int n);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         v[i*8 +: 8] = d[i*8 +: 8];
      return v;
   endfunction

   function automatic logic [KW-1:0] keep_n(input int n);
      logic [KW-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         v[i] = 1'b1;
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish required finish");
      $fatal(1);
   end

   logic [DW-1:0] d, b0, b1;
   beat_t         e;
   beat_t         exp_q[$];
   logic [7:0]    bq[$];
   logic [31:0]   seq;
   int            base, p0, r0, n, nb, nl;

   initial begin
      // Reset state
      idle(3);
      check("rst_in_tready", DW'(in_tready), DW'(0));
      check("rst_out_tvalid", DW'(out_tvalid), DW'(0));
      check("rst_out_tdata", out_tdata, '0);
      check("rst_out_tkeep", DW'(out_tkeep), DW'(0));
      check("rst_out_tlast", DW'(out_tlast), DW'(0));
      check("rst_seq_err", DW'(seq_err), DW'(0));
      check("rst_err_count", DW'(err_count), DW'(0));
      check("rst_pkt_count", DW'(pkt_count), DW'(0));
      check("rst_last_seq", DW'(last_seq), DW'(0));
      reset = 1'b0;
      idle(2);

      // Single full beat, seq 0: tail spills into one flushed beat
      base = cap_q.size();
      p0   = n_pulse;
      d = rnd_data();
      d[31:0] = 32'd0;
      send(d, '1, 1'b1);
      idle(4);
      check("t1_count", DW'(cap_q.size() - base), DW'(1));
      e.d = d >> 32;
      e.k = 64'h0FFF_FFFF_FFFF_FFFF;
      e.l = 1'b1;
      check_beat("t1_b0", base, e);
      check("t1_pulse", DW'(n_pulse - p0), DW'(0));
      check("t1_pkt_count", DW'(pkt_count), DW'(1));
      check("t1_last_seq", DW'(last_seq), DW'(0));

      // Two beats, tail of 4 bytes fits exactly: one full output beat
      base = cap_q.size();
      b0 = rnd_data();
      b0[31:0] = 32'd1;
      b1 = mask_data(rnd_data(), 4);
      send(b0, '1, 1'b0);
      send(b1, 64'hF, 1'b1);
      idle(4);
      check("t2_count", DW'(cap_q.size() - base), DW'(1));
      e.d = {b1[31:0], b0[511:32]};
      e.k = '1;
      e.l = 1'b1;
      check_beat("t2_b0", base, e);

      // Two beats, tail of 8 bytes: two output beats and one input bubble
      base = cap_q.size();
      r0   = n_rdy_low;
      b0 = rnd_data();
      b0[31:0] = 32'd2;
      b1 = mask_data(rnd_data(), 8);
      send(b0, '1, 1'b0);
      send(b1, 64'hFF, 1'b1);
      idle(4);
      check("t3_count", DW'(cap_q.size() - base), DW'(2));
      e.d = {b1[31:0], b0[511:32]};
      e.k = '1;
      e.l = 1'b0;
      check_beat("t3_b0", base, e);
      e.d = DW'(b1[63:32]);
      e.k = 64'hF;
      e.l = 1'b1;
      check_beat("t3_b1", base + 1, e);
      check("t3_ready_low", DW'(n_rdy_low - r0), DW'(1));

      // Header-only packet
      base = cap_q.size();
      send(DW'(32'd3), 64'hF, 1'b1);
      idle(4);
      check("t4_count", DW'(cap_q.size() - base), DW'(0));
      check("t4_pkt_count", DW'(pkt_count), DW'(4));
      check("t4_last_seq", DW'(last_seq), DW'(3));

      // Sequence 4, 9, 10: one error on the jump, resync afterwards
      p0 = n_pulse;
      send(DW'(32'd4), 64'hF, 1'b1);
      idle(2);
      check("t5_pulse_4", DW'(n_pulse - p0), DW'(0));
      send(DW'(32'd9), 64'hF, 1'b1);
      idle(2);
      check("t5_pulse_9", DW'(n_pulse - p0), DW'(1));
      check("t5_err_count_9", DW'(err_count), DW'(1));
      send(DW'(32'd10), 64'hF, 1'b1);
      idle(2);
      check("t5_pulse_10", DW'(n_pulse - p0), DW'(1));
      check("t5_err_count_10", DW'(err_count), DW'(1));
      check("t5_last_seq", DW'(last_seq), DW'(10));
      check("t5_pkt_count", DW'(pkt_count), DW'(7));

      // Random backpressure, 20 packets, byte-stream reference model
      rand_rdy = 1'b1;
      base = cap_q.size();
      seq  = 32'd11;
      for (int p = 0; p < 20; p++) begin
         nb = $urandom_range(1, 5);
         nl = (nb == 1) ? $urandom_range(4, KW) : $urandom_range(1, KW);
         bq.delete();
         for (int b = 0; b < nb; b++) begin
            n = (b == nb - 1) ? nl : KW;
            d = mask_data(rnd_data(), n);
            if (b == 0)
               d[31:0] = seq;
            for (int i = 0; i < n; i++)
               bq.push_back(d[i*8 +: 8]);
            send(d, keep_n(n), b == nb - 1);
         end
         for (int i = 0; i < 4; i++)
            void'(bq.pop_front());
         while (bq.size() > 0) begin
            e = '0;
            for (int i = 0; i < KW && bq.size() > 0; i++) begin
               e.d[i*8 +: 8] = bq.pop_front();
               e.k[i] = 1'b1;
            end
            e.l = (bq.size() == 0);
            exp_q.push_back(e);
         end
         seq = seq + 32'd1;
      end
      rand_rdy   = 1'b0;
      out_tready = 1'b1;
      idle(20);
      check("t6_count", DW'(cap_q.size() - base), DW'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check_beat("t6_beat", base + i, exp_q[i]);
      check("t6_stall_stable", DW'(n_stab), DW'(0));
      check("t6_pkt_count", DW'(pkt_count), DW'(27));
      check("t6_err_count", DW'(err_count), DW'(1));
      check("t6_last_seq", DW'(last_seq), DW'(30));

      // Reset mid-packet with a stalled output beat pending
      out_tready = 1'b0;
      d = rnd_data();
      d[31:0] = 32'd31;
      send(d, '1, 1'b0);
      send(rnd_data(), '1, 1'b0);
      check("t7_pending_valid", DW'(out_tvalid), DW'(1));
      reset = 1'b1;
      tick();
      check("t7_rst_in_tready", DW'(in_tready), DW'(0));
      check("t7_rst_out_tvalid", DW'(out_tvalid), DW'(0));
      check("t7_rst_out_tdata", out_tdata, '0);
      tick();
      reset = 1'b0;
      check("t7_post_out_tkeep", DW'(out_tkeep), DW'(0));
      check("t7_post_out_tlast", DW'(out_tlast), DW'(0));
      check("t7_post_err_count", DW'(err_count), DW'(0));
      check("t7_post_pkt_count", DW'(pkt_count), DW'(0));
      check("t7_post_last_seq", DW'(last_seq), DW'(0));
      out_tready = 1'b1;
      idle(1);
      base = cap_q.size();
      p0   = n_pulse;
      b1 = mask_data(rnd_data(), 8);
      b1[31:0] = 32'd0;
      send(b1, 64'hFF, 1'b1);
      idle(4);
      check("t7_count", DW'(cap_q.size() - base), DW'(1));
      e.d = DW'(b1[63:32]);
      e.k = 64'hF;
      e.l = 1'b1;
      check_beat("t7_b0", base, e);
      check("t7_pulse", DW'(n_pulse - p0), DW'(0));
      check("t7_err_count", DW'(err_count), DW'(0));
      check("t7_pkt_count", DW'(pkt_count), DW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/counter_header_stripper.md
Name: counter_header_stripper

Overview:
- Receive-side counterpart of the counter header inserter: accepts an AXI-Stream packet whose first HDR_BYTES bytes carry a 32-bit little-endian sequence counter.
- Removes the header and re-aligns the payload down by HDR_BYTES across beats.
- Checks the sequence against an expected count and reports errors and packet counts.
- Sits at the stream sink, just before payload consumers.

Parameters:
- DW, 512, data width in bits (multiple of 64).
- HDR_BYTES, 4, header length in bytes; fixed at 4 (32-bit counter).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- AXIS_IN_TDATA  in  DW  input stream data; byte 0 = bits [7:0].
- AXIS_IN_TVALID  in  1  input valid.
- AXIS_IN_TREADY  out  1  input ready.
- AXIS_IN_TKEEP  in  DW/8  byte enables; contiguous from byte 0.
- AXIS_IN_TLAST  in  1  end of packet.
- AXIS_OUT_TDATA  out  DW  header-stripped data (registered).
- AXIS_OUT_TVALID  out  1  output valid (registered).
- AXIS_OUT_TREADY  in  1  downstream ready.
- AXIS_OUT_TKEEP  out  DW/8  output byte enables (registered).
- AXIS_OUT_TLAST  out  1  output end of packet (registered).
- seq_err  out  1  one-cycle pulse on a sequence mismatch.
- err_count  out  32  mismatches since reset; wraps.
- pkt_count  out  32  headers accepted since reset; wraps.
- last_seq  out  32  most recent received header counter.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - All outputs 0, including AXIS_IN_TREADY.
  - State HEAD; expected counter 0; hold register and hold keep cleared.
- Reset mid-packet:
  - Packet is abandoned and any pending output beat is dropped.
  - The downstream sees no TLAST for that packet; this is acceptable.
- Output register: loads when out_free = !AXIS_OUT_TVALID || AXIS_OUT_TREADY.
- Input ready: AXIS_IN_TREADY = out_free && state != FLUSH. Input beat accepted = TVALID && TREADY.
- Definitions:
  - H = 8*HDR_BYTES.
  - hold = DW-H bit register; hold_keep = DW/8-HDR_BYTES bits.
  - rest_keep = in TKEEP[DW/8-1:HDR_BYTES].
- State HEAD, on accept:
  - seq = TDATA[31:0]; last_seq <= seq; pkt_count++.
  - If seq != expected: seq_err=1 for one cycle and err_count++.
  - expected <= seq+1 (resynchronises; wraps at 2^32).
  - hold <= TDATA[DW-1:H]; hold_keep <= rest_keep. No output beat.
  - Next state:
    - !TLAST -> BODY.
    - TLAST and rest_keep != 0 -> FLUSH.
    - TLAST and rest_keep == 0 -> HEAD; header-only packet dropped, no output.
- State BODY, on accept:
  - Output beat: TDATA = {in[H-1:0], hold}, TKEEP = {in_keep[HDR_BYTES-1:0], hold_keep}.
  - hold/hold_keep reload from in[DW-1:H] / rest_keep.
  - Next state:
    - TLAST and rest_keep == 0 -> output TLAST=1, go HEAD.
    - TLAST and rest_keep != 0 -> output TLAST=0, go FLUSH.
    - Otherwise stay in BODY.
- State FLUSH, when out_free:
  - Output TDATA = {H'b0, hold}, TKEEP = {0, hold_keep}, TLAST=1; go HEAD.
- Latency: output beat is valid one cycle after the accepting input edge.
- Throughput: one beat per cycle while downstream is ready. FLUSH costs one input bubble per packet whose tail spills.
- AXIS rules:
  - Output data, keep and last are stable while TVALID && !TREADY.
  - Output TVALID never drops without a handshake.
- seq_err and counters update on the HEAD accept cycle, independent of output backpressure.
- Non-contiguous TKEEP or a zero-keep beat is illegal input; behaviour is undefined, no check required.

Decomposition:
- Shared package:
  - HDR_BYTES constant; sequence counter width (32).
  - State enum {HEAD, BODY, FLUSH}, also reused by the inserter's testbench model.
- One sub-module is natural: axis_out_reg, the registered output stage with its out_free logic, parameterised by DW.
- The re-align and check logic stays in the top module.

Test Plan:
- Single beat, full keep, seq 0 -> one output beat:
  - TDATA = in[511:32] zero-extended, TKEEP = 0x0FFFFFFFFFFFFFFF, TLAST=1.
  - seq_err=0, pkt_count=1.
- Two beats (b0 full, b1 keep 0xF, seq 1) -> one output beat:
  - TDATA = {b1[31:0], b0[511:32]}, TKEEP all-ones, TLAST=1.
- Two beats (b0 full, b1 keep 0xFF) -> two output beats:
  - Beat 1: full keep, TLAST=0.
  - Beat 2: TDATA[31:0]=b1[63:32], TKEEP=0xF, TLAST=1.
  - Input ready low for exactly one cycle.
- Header-only packet (keep 0xF, TLAST) -> no output beat; pkt_count increments; last_seq updated.
- Sequences 0,1,5,6 -> seq_err pulses once, on seq 5; err_count=1; no error on 6 (resync).
- Random AXIS_OUT_TREADY (50%), 20 packets of 1–5 beats, then reset asserted mid-packet:
  - Stripped stream matches the reference model byte-for-byte.
  - After reset, all outputs are 0 and the next packet with seq 0 gives no error.
